huffman_param_enc: RTL and testbench

//  Parametrised successor of the fixed 6-symbol Huffman encoder. Counts one frame of FRAME_LEN symbols, builds the

---
 rtl/huffman_param_enc_if.sv | 29 ++
 rtl/huffman_param_enc.sv | 259 +++++++++++++++++++++++++
 tb/tb_huffman_param_enc.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_param_enc_if.sv
// rtl/huffman_param_enc_if.sv - symbol input handshake and code table output bundle
interface huffman_param_enc_if #(
    parameter int NSYM   = 6,
    parameter int SW     = 8,
    parameter int CW     = 8,
    parameter int MAXLEN = 8
);
    logic                   sym_valid;
    logic [SW-1:0]          sym_data;
    logic                   sym_ready;
    logic                   cnt_valid;
    logic [NSYM*CW-1:0]     cnt_o;
    logic                   code_valid;
    logic [NSYM*MAXLEN-1:0] hc_o;
    logic [NSYM*MAXLEN-1:0] m_o;
    logic                   err;

    // source/consumer side
    modport master (
        output sym_valid, sym_data,
        input  sym_ready, cnt_valid, cnt_o, code_valid, hc_o, m_o, err
    );

    // encoder side
    modport slave (
        input  sym_valid, sym_data,
        output sym_ready, cnt_valid, cnt_o, code_valid, hc_o, m_o, err
    );
endinterface

// File: rtl/huffman_param_enc.sv
// rtl/huffman_param_enc.sv - frame symbol counter and iterative two-minimum Huffman code builder
module huffman_param_enc #(
    parameter int NSYM      = 6,
    parameter int SW        = 8,
    parameter int CW        = 8,
    parameter int FRAME_LEN = 100,
    parameter int MAXLEN    = 8,
    parameter int SKIP_ZERO = 0
) (
    input  logic               clk,
    input  logic               reset,
    huffman_param_enc_if.slave bus
);
    localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int LW = $clog2(MAXLEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_CNTV, S_SCAN, S_MERGE, S_DONE
    } state_t;

    state_t state_q, state_d;

    // Counts are published; weights are the tree-build working copy so cnt_o stays intact.
    logic [CW-1:0]     cnt_q [NSYM];
    logic [CW-1:0]     cnt_d [NSYM];
    logic [CW-1:0]     w_q   [NSYM];
    logic [CW-1:0]     w_d   [NSYM];
    // Group id of each symbol is the lowest index (representative) of its subtree.
    logic [IW-1:0]     grp_q [NSYM];
    logic [IW-1:0]     grp_d [NSYM];
    logic [LW-1:0]     len_q [NSYM];
    logic [LW-1:0]     len_d [NSYM];
    logic [MAXLEN-1:0] hc_q  [NSYM];
    logic [MAXLEN-1:0] hc_d  [NSYM];
    logic [MAXLEN-1:0] m_q   [NSYM];
    logic [MAXLEN-1:0] m_d   [NSYM];

    logic          err_q, err_d;
    logic          merged_q, merged_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [IW-1:0] scan_q, scan_d;
    logic [IW-1:0] min1_q, min1_d, min2_q, min2_d;
    logic          min1_vld_q, min1_vld_d, min2_vld_q, min2_vld_d;

    logic          sym_ready, cnt_valid, code_valid;
    logic          xfer;
    logic [IW-1:0] sym_idx;
    logic          scan_last;
    logic          s_cand;
    logic [IW-1:0] s_min1, s_min2;
    logic          s_min1_vld, s_min2_vld;
    logic [IW-1:0] rep;

    logic [NSYM*CW-1:0]     cnt_flat;
    logic [NSYM*MAXLEN-1:0] hc_flat, m_flat;

    assign xfer      = bus.sym_valid & sym_ready;
    assign scan_last = (scan_q == IW'(NSYM - 1));
    assign rep       = (min1_q < min2_q) ? min1_q : min2_q;

    // Map an input value to its symbol index; out-of-range values fold onto the last symbol.
    always_comb begin
        sym_idx = IW'(NSYM - 1);
        if ((bus.sym_data != '0) && (bus.sym_data <= SW'(NSYM))) begin
            sym_idx = IW'(bus.sym_data - SW'(1));
        end
    end

    // Evaluate the current scan index against the two running minima (strict <, ties keep lower index).
    always_comb begin
        s_cand     = (grp_q[scan_q] == scan_q) && ((SKIP_ZERO == 0) || (w_q[scan_q] != '0));
        s_min1     = min1_q;
        s_min1_vld = min1_vld_q;
        s_min2     = min2_q;
        s_min2_vld = min2_vld_q;
        if (s_cand) begin
            if (!min1_vld_q || (w_q[scan_q] < w_q[min1_q])) begin
                s_min2     = min1_q;
                s_min2_vld = min1_vld_q;
                s_min1     = scan_q;
                s_min1_vld = 1'b1;
            end else if (!min2_vld_q || (w_q[scan_q] < w_q[min2_q])) begin
                s_min2     = scan_q;
                s_min2_vld = 1'b1;
            end
        end
    end

    // FSM next state and handshake/strobe outputs.
    always_comb begin
        state_d    = state_q;
        sym_ready  = 1'b0;
        cnt_valid  = 1'b0;
        code_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                sym_ready = 1'b1;
                if (xfer) state_d = (FRAME_LEN == 1) ? S_CNTV : S_COUNT;
            end
            S_COUNT: begin
                sym_ready = 1'b1;
                if (xfer && (in_cnt_q == CW'(FRAME_LEN - 1))) state_d = S_CNTV;
            end
            S_CNTV: begin
                cnt_valid = 1'b1;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                if (scan_last) state_d = s_min2_vld ? S_MERGE : S_DONE;
            end
            S_MERGE: state_d = S_SCAN;
            S_DONE: begin
                code_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state: counting, weight load, scan minima and group merge.
    always_comb begin
        cnt_d      = cnt_q;
        w_d        = w_q;
        grp_d      = grp_q;
        len_d      = len_q;
        hc_d       = hc_q;
        m_d        = m_q;
        err_d      = err_q;
        merged_d   = merged_q;
        in_cnt_d   = in_cnt_q;
        scan_d     = scan_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        min1_vld_d = min1_vld_q;
        min2_vld_d = min2_vld_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    // First symbol of a frame wipes the previous frame's results.
                    for (int k = 0; k < NSYM; k++) begin
                        cnt_d[k] = '0;
                        grp_d[k] = IW'(k);
                        len_d[k] = '0;
                        hc_d[k]  = '0;
                        m_d[k]   = '0;
                    end
                    cnt_d[sym_idx] = CW'(1);
                    err_d          = 1'b0;
                    merged_d       = 1'b0;
                    in_cnt_d       = CW'(1);
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    cnt_d[sym_idx] = cnt_q[sym_idx] + CW'(1);
                    in_cnt_d       = in_cnt_q + CW'(1);
                end
            end
            S_CNTV: begin
                w_d        = cnt_q;
                in_cnt_d   = '0;
                scan_d     = '0;
                min1_vld_d = 1'b0;
                min2_vld_d = 1'b0;
            end
            S_SCAN: begin
                min1_d     = s_min1;
                min1_vld_d = s_min1_vld;
                min2_d     = s_min2;
                min2_vld_d = s_min2_vld;
                scan_d     = scan_q + IW'(1);
                // A lone surviving symbol with no merges still needs a one-bit code.
                if (scan_last && !s_min2_vld && !merged_q && s_min1_vld) begin
                    hc_d[s_min1] = '0;
                    m_d[s_min1]  = MAXLEN'(1);
                end
            end
            S_MERGE: begin
                for (int k = 0; k < NSYM; k++) begin
                    if ((grp_q[k] == min1_q) || (grp_q[k] == min2_q)) begin
                        grp_d[k] = rep;
                        if (len_q[k] == LW'(MAXLEN)) begin
                            err_d = 1'b1;
                        end else begin
                            if (grp_q[k] == min1_q) hc_d[k] = hc_q[k] | (MAXLEN'(1) << len_q[k]);
                            len_d[k] = len_q[k] + LW'(1);
                            m_d[k]   = (m_q[k] << 1) | MAXLEN'(1);
                        end
                    end
                end
                w_d[rep]   = w_q[min1_q] + w_q[min2_q];
                merged_d   = 1'b1;
                scan_d     = '0;
                min1_vld_d = 1'b0;
                min2_vld_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            for (int k = 0; k < NSYM; k++) begin
                cnt_q[k] <= '0;
                w_q[k]   <= '0;
                grp_q[k] <= '0;
                len_q[k] <= '0;
                hc_q[k]  <= '0;
                m_q[k]   <= '0;
            end
            err_q      <= 1'b0;
            merged_q   <= 1'b0;
            in_cnt_q   <= '0;
            scan_q     <= '0;
            min1_q     <= '0;
            min2_q     <= '0;
            min1_vld_q <= 1'b0;
            min2_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            grp_q      <= grp_d;
            len_q      <= len_d;
            hc_q       <= hc_d;
            m_q        <= m_d;
            err_q      <= err_d;
            merged_q   <= merged_d;
            in_cnt_q   <= in_cnt_d;
            scan_q     <= scan_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            min1_vld_q <= min1_vld_d;
            min2_vld_q <= min2_vld_d;
        end
    end

    // Flatten per-symbol registers onto the output buses.
    always_comb begin
        cnt_flat = '0;
        hc_flat  = '0;
        m_flat   = '0;
        for (int k = 0; k < NSYM; k++) begin
            cnt_flat[k*CW +: CW]         = cnt_q[k];
            hc_flat[k*MAXLEN +: MAXLEN]  = hc_q[k];
            m_flat[k*MAXLEN +: MAXLEN]   = m_q[k];
        end
    end

    assign bus.sym_ready  = sym_ready;
    assign bus.cnt_valid  = cnt_valid;
    assign bus.code_valid = code_valid;
    assign bus.cnt_o      = cnt_flat;
    assign bus.hc_o       = hc_flat;
    assign bus.m_o        = m_flat;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_huffman_param_enc.sv
// tb/tb_huffman_param_enc.sv - scoreboard bench for huffman_param_enc across three configurations
module tb_huffman_param_enc;
    logic clk;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // a: NSYM=4 full tree, b: NSYM=4 zero-skip, c: NSYM=6 MAXLEN=2 (overflow)
    huffman_param_enc_if #(.NSYM(4), .SW(8), .CW(8), .MAXLEN(8)) ia ();
    huffman_param_enc_if #(.NSYM(4), .SW(8), .CW(8), .MAXLEN(8)) ib ();
    huffman_param_enc_if #(.NSYM(6), .SW(8), .CW(8), .MAXLEN(2)) ic ();

    huffman_param_enc #(.NSYM(4), .SW(8), .CW(8), .FRAME_LEN(8), .MAXLEN(8), .SKIP_ZERO(0))
        dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    huffman_param_enc #(.NSYM(4), .SW(8), .CW(8), .FRAME_LEN(8), .MAXLEN(8), .SKIP_ZERO(1))
        dut_b (.clk(clk), .reset(rst_b), .bus(ib));
    huffman_param_enc #(.NSYM(6), .SW(8), .CW(8), .FRAME_LEN(100), .MAXLEN(2), .SKIP_ZERO(0))
        dut_c (.clk(clk), .reset(rst_c), .bus(ic));

    logic [2:0]  rdy, cv, kv, er;
    logic [47:0] cnt_w [3];
    logic [47:0] hc_w  [3];
    logic [47:0] m_w   [3];

    assign rdy = {ic.sym_ready, ib.sym_ready, ia.sym_ready};
    assign cv  = {ic.cnt_valid, ib.cnt_valid, ia.cnt_valid};
    assign kv  = {ic.code_valid, ib.code_valid, ia.code_valid};
    assign er  = {ic.err, ib.err, ia.err};
    assign cnt_w[0] = 48'(ia.cnt_o);
    assign cnt_w[1] = 48'(ib.cnt_o);
    assign cnt_w[2] = ic.cnt_o;
    assign hc_w[0]  = 48'(ia.hc_o);
    assign hc_w[1]  = 48'(ib.hc_o);
    assign hc_w[2]  = 48'(ic.hc_o);
    assign m_w[0]   = 48'(ia.m_o);
    assign m_w[1]   = 48'(ib.m_o);
    assign m_w[2]   = 48'(ic.m_o);

    typedef struct {
        int          inst;
        logic [47:0] cnt;
        logic [47:0] hc;
        logic [47:0] m;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   t0[3];

    logic [7:0] s_t1 [8] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4};
    logic [7:0] s_t4 [8] = '{8'd0, 8'd200, 8'd3, 8'd3, 8'd1, 8'd2, 8'd4, 8'd4};
    logic [7:0] s_b1 [8] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    logic [7:0] s_b2 [8] = '{8'd1, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};

    localparam logic [47:0] A_CNT = 48'h0000_0402_0101;
    localparam logic [47:0] A_HC  = 48'h0000_0002_0607;
    localparam logic [47:0] A_M   = 48'h0000_0103_0707;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    function automatic int find_inst(input int inst);
        foreach (sb[k]) if (sb[k].inst == inst) return k;
        return -1;
    endfunction

    task automatic expect_frame(input int inst, input logic [47:0] c, input logic [47:0] h,
                                input logic [47:0] m, input logic e, input int lat);
        exp_t x;
        x.inst = inst; x.cnt = c; x.hc = h; x.m = m; x.err = e; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic set_in(input int i, input logic v, input logic [7:0] d);
        case (i)
            0: begin ia.sym_valid = v; ia.sym_data = d; end
            1: begin ib.sym_valid = v; ib.sym_data = d; end
            default: begin ic.sym_valid = v; ic.sym_data = d; end
        endcase
    endtask

    task automatic send(input int i, input logic [7:0] v);
        int n = 0;
        set_in(i, 1'b1, v);
        while (!rdy[i] && n < 300) begin @(posedge clk); #1; n++; end
        if (!rdy[i]) timeout($sformatf("send_ready[%0d]", i));
        @(posedge clk); #1;
        set_in(i, 1'b0, 8'd0);
    endtask

    task automatic send_seq(input int i, input logic [7:0] s [8], input int gap);
        for (int k = 0; k < 8; k++) begin
            send(i, s[k]);
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_code(input int i);
        int n = 0;
        while (!kv[i] && n < 300) begin @(posedge clk); #1; n++; end
        if (!kv[i]) timeout($sformatf("code_valid[%0d]", i));
        set_in(i, 1'b0, 8'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: checks counts on cnt_valid, codes and latency on code_valid.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (cv[i]) begin
                idx = find_inst(i);
                if (idx < 0) timeout($sformatf("unexpected_cnt_valid[%0d]", i));
                else begin
                    e = sb[idx];
                    chk($sformatf("cnt_at_cntv[%0d]", i), cnt_w[i], e.cnt);
                    t0[i] = cyc;
                end
                chk($sformatf("ready_at_cntv[%0d]", i), 48'(rdy[i]), 48'h0);
            end
            if (kv[i]) begin
                idx = find_inst(i);
                if (idx < 0) timeout($sformatf("unexpected_code_valid[%0d]", i));
                else begin
                    e = sb[idx];
                    sb.delete(idx);
                    chk($sformatf("latency[%0d]", i), 48'(cyc - t0[i]), 48'(e.lat));
                    chk($sformatf("hc[%0d]", i), hc_w[i], e.hc);
                    chk($sformatf("mask[%0d]", i), m_w[i], e.m);
                    chk($sformatf("err[%0d]", i), 48'(er[i]), 48'(e.err));
                    chk($sformatf("cnt_at_code[%0d]", i), cnt_w[i], e.cnt);
                end
                chk($sformatf("ready_at_code[%0d]", i), 48'(rdy[i]), 48'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i += 2) begin
            chk($sformatf("rst_ready[%0d]", i), 48'(rdy[i]), 48'h1);
            chk($sformatf("rst_strobes[%0d]", i), 48'({cv[i], kv[i], er[i]}), 48'h0);
            chk($sformatf("rst_cnt[%0d]", i), cnt_w[i], 48'h0);
            chk($sformatf("rst_hc_m[%0d]", i), hc_w[i] | m_w[i], 48'h0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(posedge clk); #1;

        // Basic frame; symbols offered during the build must be ignored.
        expect_frame(0, A_CNT, A_HC, A_M, 1'b0, 20);
        send_seq(0, s_t1, 0);
        set_in(0, 1'b1, 8'd2);
        wait_code(0);

        // Same stream with idle gaps.
        expect_frame(0, A_CNT, A_HC, A_M, 1'b0, 20);
        send_seq(0, s_t1, 1);
        wait_code(0);

        // Out-of-range values fold onto the last symbol.
        expect_frame(0, A_CNT, A_HC, A_M, 1'b0, 20);
        send_seq(0, s_t4, 0);
        wait_code(0);

        // Reset in the middle of the first scan pass.
        expect_frame(0, A_CNT, A_HC, A_M, 1'b0, 20);
        send_seq(0, s_t1, 0);
        n = 0;
        while (!cv[0] && n < 50) begin @(posedge clk); #1; n++; end
        if (!cv[0]) timeout("abort_cnt_valid");
        repeat (2) begin @(posedge clk); #1; end
        rst_a = 1'b1;
        #2;
        chk("abort_ready", 48'(rdy[0]), 48'h1);
        chk("abort_strobes", 48'({cv[0], kv[0], er[0]}), 48'h0);
        chk("abort_cnt", cnt_w[0], 48'h0);
        chk("abort_hc_m", hc_w[0] | m_w[0], 48'h0);
        idx = find_inst(0);
        if (idx >= 0) sb.delete(idx);
        @(posedge clk); #1;
        rst_a = 1'b0;
        expect_frame(0, A_CNT, A_HC, A_M, 1'b0, 20);
        send_seq(0, s_t1, 0);
        wait_code(0);

        // Zero-skip: a single live symbol, then two live symbols.
        expect_frame(1, 48'h0000_0000_0800, 48'h0, 48'h0000_0000_0100, 1'b0, 5);
        send_seq(1, s_b1, 0);
        wait_code(1);
        expect_frame(1, 48'h0000_0005_0003, 48'h0000_0000_0001, 48'h0000_0001_0001, 1'b0, 10);
        send_seq(1, s_b2, 0);
        wait_code(1);

        // Code length overflow, then an independent back-to-back frame.
        expect_frame(2, 48'h1919_140F_0A05, 48'h6CB, 48'hFFF, 1'b1, 42);
        for (int k = 0; k < 5;  k++) send(2, 8'd1);
        for (int k = 0; k < 10; k++) send(2, 8'd2);
        for (int k = 0; k < 15; k++) send(2, 8'd3);
        for (int k = 0; k < 20; k++) send(2, 8'd4);
        for (int k = 0; k < 25; k++) send(2, 8'd5);
        for (int k = 0; k < 25; k++) send(2, 8'd6);
        wait_code(2);
        chk("hold_hc", hc_w[2], 48'h6CB);
        chk("hold_err", 48'(er[2]), 48'h1);
        expect_frame(2, 48'h0000_0000_3232, 48'hAB2, 48'hFF7, 1'b1, 42);
        send(2, 8'd1);
        chk("clear_cnt", cnt_w[2], 48'h1);
        chk("clear_hc_m", hc_w[2] | m_w[2], 48'h0);
        chk("clear_err", 48'(er[2]), 48'h0);
        for (int k = 0; k < 49; k++) send(2, 8'd1);
        for (int k = 0; k < 50; k++) send(2, 8'd2);
        wait_code(2);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 48'(sb.size()), 48'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
